// File: rtl/keypad_input_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : keypad_input_ctrl_if
// Brief    : Keypad input controller bus: scanner code, CPU request/handshake,
//            and display export.
// Revision : 1.0 - initial release
// ============================================================================
interface keypad_input_ctrl_if #(
    parameter int MAX_DIGITS = 8
);
    logic [4:0]              key;
    logic                    rd_req;
    logic                    out_ready;
    logic                    out_valid;
    logic [31:0]             out_data;
    logic                    waiting;
    logic [4*MAX_DIGITS-1:0] disp_bcd;
    logic [3:0]              disp_cnt;
    logic                    disp_neg;

    modport master (
        output key, rd_req, out_ready,
        input  out_valid, out_data, waiting, disp_bcd, disp_cnt, disp_neg
    );

    modport slave (
        input  key, rd_req, out_ready,
        output out_valid, out_data, waiting, disp_bcd, disp_cnt, disp_neg
    );
endinterface
`default_nettype wire

// File: rtl/keypad_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : keypad_input_ctrl
// Brief    : Debounces keypad codes into press events, builds a signed BCD
//            entry and converts it to 32-bit binary on Enter.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_input_ctrl #(
    parameter int MAX_DIGITS    = 8,
    parameter int STABLE_CYCLES = 50000
) (
    input  logic                clk,
    input  logic                rst_n,
    keypad_input_ctrl_if.slave  bus
);
    localparam int              c_BW      = 4 * MAX_DIGITS;
    localparam int              c_RW      = $clog2(STABLE_CYCLES + 1);
    localparam logic [c_RW-1:0] c_STABLE  = c_RW'(STABLE_CYCLES);
    localparam logic [3:0]      c_MAXD    = 4'(MAX_DIGITS);
    localparam logic [4:0]      c_NO_KEY  = 5'b10000;

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_COLLECT = 2'd1;
    localparam logic [1:0] c_ST_CONVERT = 2'd2;
    localparam logic [1:0] c_ST_DONE    = 2'd3;

    logic [4:0]      w_key;
    logic [4:0]      r_sample;
    logic [c_RW-1:0] r_run;
    logic            r_armed;
    logic            w_press;

    logic [1:0]      r_state,     w_state_nxt;
    logic [c_BW-1:0] r_bcd,       w_bcd_nxt;
    logic [3:0]      r_cnt,       w_cnt_nxt;
    logic            r_neg,       w_neg_nxt;
    logic [3:0]      r_idx,       w_idx_nxt;
    logic [31:0]     r_acc,       w_acc_nxt;
    logic            r_out_valid, w_valid_nxt;
    logic [31:0]     r_out_data,  w_data_nxt;
    logic            r_waiting;

    logic [c_BW-1:0] w_shl;
    logic [c_BW-1:0] w_sel;
    logic [3:0]      w_nib;
    logic [31:0]     w_acc10;

    // Every code with bit4 set collapses to one "no key" value.
    assign w_key   = bus.key[4] ? c_NO_KEY : bus.key;
    assign w_press = r_armed && !r_sample[4] && (r_run == c_STABLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sample <= c_NO_KEY;
            r_run    <= '0;
            r_armed  <= 1'b1;
        end else begin
            r_sample <= w_key;
            if (w_key != r_sample)
                r_run <= c_RW'(1);
            else if (r_run != c_STABLE)
                r_run <= r_run + c_RW'(1);
            if (w_press)
                r_armed <= 1'b0;
            else if (r_sample[4] && (r_run == c_STABLE))
                r_armed <= 1'b1;
        end
    end

    assign w_shl   = (r_bcd << 4) | c_BW'(r_sample[3:0]);
    assign w_sel   = r_bcd >> {r_idx - 4'd1, 2'b00};
    assign w_nib   = w_sel[3:0];
    assign w_acc10 = (r_acc << 3) + (r_acc << 1) + {28'd0, w_nib};

    always_comb begin
        w_state_nxt = r_state;
        w_bcd_nxt   = r_bcd;
        w_cnt_nxt   = r_cnt;
        w_neg_nxt   = r_neg;
        w_idx_nxt   = r_idx;
        w_acc_nxt   = r_acc;
        w_valid_nxt = r_out_valid;
        w_data_nxt  = r_out_data;
        case (r_state)
            c_ST_IDLE: begin
                if (bus.rd_req) begin
                    w_state_nxt = c_ST_COLLECT;
                    w_bcd_nxt   = '0;
                    w_cnt_nxt   = 4'd0;
                    w_neg_nxt   = 1'b0;
                end
            end
            c_ST_COLLECT: begin
                if (!bus.rd_req) begin
                    w_state_nxt = c_ST_IDLE;
                    w_bcd_nxt   = '0;
                    w_cnt_nxt   = 4'd0;
                    w_neg_nxt   = 1'b0;
                end else if (w_press) begin
                    case (r_sample[3:0])
                        4'hA: begin
                            if (r_cnt != 4'd0) begin
                                w_bcd_nxt = r_bcd >> 4;
                                w_cnt_nxt = r_cnt - 4'd1;
                            end
                        end
                        4'hB: w_neg_nxt = ~r_neg;
                        4'hC, 4'hD: ;
                        4'hE: begin
                            w_bcd_nxt = '0;
                            w_cnt_nxt = 4'd0;
                            w_neg_nxt = 1'b0;
                        end
                        4'hF: begin
                            w_idx_nxt   = r_cnt;
                            w_acc_nxt   = 32'd0;
                            w_state_nxt = c_ST_CONVERT;
                        end
                        default: begin
                            if (r_cnt < c_MAXD) begin
                                w_bcd_nxt = w_shl;
                                w_cnt_nxt = r_cnt + 4'd1;
                            end
                        end
                    endcase
                end
            end
            c_ST_CONVERT: begin
                // Most significant digit sits at the highest occupied nibble.
                if (r_idx != 4'd0) begin
                    w_acc_nxt = w_acc10;
                    w_idx_nxt = r_idx - 4'd1;
                end else begin
                    w_data_nxt  = r_neg ? (~r_acc + 32'd1) : r_acc;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                if (bus.out_ready) begin
                    w_valid_nxt = 1'b0;
                    w_bcd_nxt   = '0;
                    w_cnt_nxt   = 4'd0;
                    w_neg_nxt   = 1'b0;
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_bcd       <= '0;
            r_cnt       <= 4'd0;
            r_neg       <= 1'b0;
            r_idx       <= 4'd0;
            r_acc       <= 32'd0;
            r_out_valid <= 1'b0;
            r_out_data  <= 32'd0;
            r_waiting   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bcd       <= w_bcd_nxt;
            r_cnt       <= w_cnt_nxt;
            r_neg       <= w_neg_nxt;
            r_idx       <= w_idx_nxt;
            r_acc       <= w_acc_nxt;
            r_out_valid <= w_valid_nxt;
            r_out_data  <= w_data_nxt;
            r_waiting   <= (w_state_nxt == c_ST_COLLECT);
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.waiting   = r_waiting;
    assign bus.disp_bcd  = r_bcd;
    assign bus.disp_cnt  = r_cnt;
    assign bus.disp_neg  = r_neg;
endmodule
`default_nettype wire

// File: tb/tb_keypad_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_input_ctrl
// Brief    : Self-checking bench for keypad_input_ctrl against a key-level
//            entry model (digit list, sign flag, decimal value).
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_input_ctrl;
    localparam int         c_MAXD   = 8;
    localparam logic [4:0] c_NO_KEY = 5'b10000;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    // Reference entry: digits in entry order plus the sign flag.
    int   m_digits[$];
    bit   m_neg;

    keypad_input_ctrl_if #(.MAX_DIGITS(c_MAXD)) kb ();

    keypad_input_ctrl #(
        .MAX_DIGITS    (c_MAXD),
        .STABLE_CYCLES (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (kb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] model_bcd();
        logic [31:0] b = 32'd0;
        int n = m_digits.size();
        for (int i = 0; i < n; i++)
            b[4*(n-1-i) +: 4] = 4'(m_digits[i]);
        return b;
    endfunction

    function automatic logic [31:0] model_value();
        longint v = 0;
        longint p = 1;
        for (int i = m_digits.size() - 1; i >= 0; i--) begin
            v += m_digits[i] * p;
            p *= 10;
        end
        if (m_neg) v = -v;
        return v[31:0];
    endfunction

    task automatic model_apply(input int k);
        if (k <= 9) begin
            if (m_digits.size() < c_MAXD) m_digits.push_back(k);
        end else if (k == 10) begin
            if (m_digits.size() > 0) void'(m_digits.pop_back());
        end else if (k == 11) begin
            m_neg = !m_neg;
        end else if (k == 14) begin
            m_digits.delete();
            m_neg = 1'b0;
        end
    endtask

    task automatic press(input logic [3:0] k, input bit track);
        kb.key = {1'b0, k};
        tick(10);
        kb.key = c_NO_KEY;
        tick(10);
        if (track) begin
            model_apply(int'(k));
            check("cnt", 32'(kb.disp_cnt), 32'(m_digits.size()));
            check("bcd", kb.disp_bcd, model_bcd());
            check("neg", 32'(kb.disp_neg), 32'(m_neg));
        end
    endtask

    task automatic enter(input int hold, input bit handshake);
        logic [31:0] exp;
        int n;
        int t;
        int lat;
        exp = model_value();
        n   = m_digits.size();
        kb.key = 5'd15;
        t = 0;
        while (kb.waiting && t < 40) begin
            tick(1);
            t++;
        end
        check("enter_seen", 32'(kb.waiting), 32'd0);
        lat = 0;
        while (!kb.out_valid && lat < 40) begin
            tick(1);
            lat++;
        end
        check("latency", 32'(lat), 32'(n + 1));
        check("out_data", kb.out_data, exp);
        kb.key = c_NO_KEY;
        if (handshake) begin
            tick(hold);
            check("hold_valid", 32'(kb.out_valid), 32'd1);
            check("hold_data", kb.out_data, exp);
            kb.out_ready = 1'b1;
            tick(1);
            kb.out_ready = 1'b0;
            check("hs_valid", 32'(kb.out_valid), 32'd0);
            check("hs_cnt", 32'(kb.disp_cnt), 32'd0);
            check("hs_data", kb.out_data, exp);
            m_digits.delete();
            m_neg = 1'b0;
            tick(10);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        m_neg        = 1'b0;
        rst_n        = 1'b0;
        kb.key       = c_NO_KEY;
        kb.rd_req    = 1'b0;
        kb.out_ready = 1'b0;
        tick(3);
        check("rst_valid", 32'(kb.out_valid), 32'd0);
        check("rst_data", kb.out_data, 32'd0);
        check("rst_wait", 32'(kb.waiting), 32'd0);
        check("rst_bcd", kb.disp_bcd, 32'd0);
        check("rst_cnt", 32'(kb.disp_cnt), 32'd0);
        check("rst_neg", 32'(kb.disp_neg), 32'd0);
        rst_n = 1'b1;
        tick(10);

        // Presses in IDLE are dropped.
        press(4'd5, 1'b0);
        check("idle_cnt", 32'(kb.disp_cnt), 32'd0);
        check("idle_valid", 32'(kb.out_valid), 32'd0);

        kb.rd_req = 1'b1;
        tick(2);
        check("wait_on", 32'(kb.waiting), 32'd1);
        press(4'd1, 1'b1);
        press(4'd2, 1'b1);
        press(4'd3, 1'b1);
        check("bcd_123", {20'd0, kb.disp_bcd[11:0]}, 32'h123);
        enter(20, 1'b1);

        press(4'd4, 1'b1);
        press(4'd5, 1'b1);
        press(4'hA, 1'b1);
        press(4'd7, 1'b1);
        press(4'hB, 1'b1);
        check("neg47", model_value(), 32'hFFFF_FFD1);
        enter(3, 1'b1);
        press(4'd6, 1'b1);
        press(4'hE, 1'b1);
        enter(3, 1'b1);

        repeat (9) press(4'd9, 1'b1);
        check("sat_cnt", 32'(kb.disp_cnt), 32'd8);
        check("sat_val", model_value(), 32'h05F5_E0FF);
        enter(3, 1'b1);

        // Bounces shorter than the stable window yield nothing.
        kb.key = 5'd3; tick(2);
        kb.key = c_NO_KEY; tick(1);
        kb.key = 5'd3; tick(2);
        kb.key = c_NO_KEY; tick(10);
        check("bounce_cnt", 32'(kb.disp_cnt), 32'd0);
        kb.key = 5'd3; tick(40);
        kb.key = c_NO_KEY; tick(2);
        model_apply(3);
        check("long_cnt", 32'(kb.disp_cnt), 32'd1);
        kb.key = 5'd3; tick(10);
        kb.key = c_NO_KEY; tick(10);
        check("rearm_cnt", 32'(kb.disp_cnt), 32'd1);
        press(4'hE, 1'b1);

        for (int r = 0; r < 6; r++) begin
            int n;
            n = int'($urandom_range(1, 12));
            for (int i = 0; i < n; i++)
                press(4'($urandom_range(0, 14)), 1'b1);
            enter(3, 1'b1);
        end

        // Dropping rd_req abandons the entry.
        press(4'd8, 1'b1);
        press(4'd2, 1'b1);
        kb.rd_req = 1'b0;
        tick(2);
        m_digits.delete();
        m_neg = 1'b0;
        check("abort_cnt", 32'(kb.disp_cnt), 32'd0);
        check("abort_wait", 32'(kb.waiting), 32'd0);
        check("abort_valid", 32'(kb.out_valid), 32'd0);

        kb.rd_req = 1'b1;
        tick(10);
        press(4'd7, 1'b1);
        enter(0, 1'b0);
        tick(2);
        rst_n = 1'b0;
        #1;
        check("rst_done_valid", 32'(kb.out_valid), 32'd0);
        check("rst_done_data", kb.out_data, 32'd0);
        check("rst_done_cnt", 32'(kb.disp_cnt), 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
